// File: rtl/sar_pkg.sv
// Shared SAR constants and helpers, also used by the sarlogic wrapper.
package sar_pkg;

    localparam int unsigned SAR_DATA_W     = 12;
    localparam int unsigned SAR_LOG2_N_MAX = 4;

    // Sample counter width; a zero-bit counter is not legal, so floor at 1.
    function automatic int unsigned sar_cnt_width(input int unsigned log2_n);
        return (log2_n > 0) ? log2_n : 1;
    endfunction

endpackage : sar_pkg

// File: rtl/sar_edge_det.sv
// Registered rising-edge detector: one pulse per 0->1 transition of level_i.
module sar_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_c
);

    logic prev_q;

    // Remember last cycle's level; reset to 0 so a level already high
    // after reset counts as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_c = level_i & ~prev_q;

endmodule : sar_edge_det

// File: rtl/sar_avg_decim.sv
// Block averager / decimator for SAR conversion codes with a
// one-deep valid/ready output and a sticky overrun flag.
module sar_avg_decim
    import sar_pkg::*;
#(
    parameter  int unsigned DATA_W = SAR_DATA_W,
    parameter  int unsigned LOG2_N = 2,
    localparam int unsigned CNT_W  = sar_cnt_width(LOG2_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bitout,
    input  logic              conv_done,
    input  logic              flush,
    input  logic              ovr_clr,
    input  logic              avg_ready,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              overrun,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int unsigned ACC_W      = DATA_W + LOG2_N;
    localparam int unsigned BLOCK_LAST = (1 << LOG2_N) - 1;

    logic              capture_c;
    logic              take_c;
    logic              done_c;
    logic              xfer_c;
    logic              ovr_ev_c;
    logic [ACC_W-1:0]  sum_c;
    logic [DATA_W-1:0] res_c;

    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] avg_q,   avg_d;
    logic              valid_q, valid_d;
    logic              ovr_q,   ovr_d;

    sar_edge_det u_edge (
        .clk     (clk),
        .reset   (reset),
        .level_i (conv_done),
        .rise_c  (capture_c)
    );

    // Accumulate samples, close a block every 2^LOG2_N captures and
    // hand the result to the one-entry output register.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        avg_d    = avg_q;
        valid_d  = valid_q;
        ovr_ev_c = 1'b0;

        // Accumulator is wide enough that a full block never wraps.
        sum_c  = acc_q + ACC_W'(bitout);
        res_c  = DATA_W'(sum_c >> LOG2_N);
        // flush discards a same-cycle capture.
        take_c = capture_c & ~flush;
        done_c = take_c && (cnt_q == CNT_W'(BLOCK_LAST));
        xfer_c = valid_q & avg_ready;

        if (flush || done_c) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take_c) begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (done_c) begin
            if (!valid_q || xfer_c) begin
                avg_d   = res_c;
                valid_d = 1'b1;
            end else begin
                ovr_ev_c = 1'b1;
            end
        end else if (xfer_c) begin
            valid_d = 1'b0;
        end

        // A new drop beats a same-cycle clear so no overrun is lost.
        if (ovr_ev_c) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign avg_out    = avg_q;
    assign avg_valid  = valid_q;
    assign overrun    = ovr_q;
    assign sample_cnt = cnt_q;

endmodule : sar_avg_decim

// File: tb/tb_sar_avg_decim.sv
// Self-checking bench for sar_avg_decim: directed scenarios plus a
// randomized run against a sample-list reference model (N=4 and N=1).
module tb_sar_avg_decim;

    logic        clk;
    logic        reset;
    logic [11:0] bitout;
    logic        conv_done;
    logic        flush;
    logic        ovr_clr;
    logic        avg_ready;

    logic [11:0] out2;
    logic        valid2;
    logic        ovr2;
    logic [1:0]  cnt2;
    logic [11:0] out0;
    logic        valid0;
    logic        ovr0;
    logic [0:0]  cnt0;

    int checks = 0;
    int errors = 0;

    // Reference model state: [0] averages 4 samples, [1] passes through.
    int m_out   [2];
    bit m_valid [2];
    bit m_ovr   [2];
    bit m_prev  [2];
    int m_blk   [2][16];
    int m_n     [2];

    sar_avg_decim #(.DATA_W(12), .LOG2_N(2)) dut (
        .clk(clk), .reset(reset), .bitout(bitout), .conv_done(conv_done),
        .flush(flush), .ovr_clr(ovr_clr), .avg_ready(avg_ready),
        .avg_out(out2), .avg_valid(valid2), .overrun(ovr2), .sample_cnt(cnt2)
    );

    sar_avg_decim #(.DATA_W(12), .LOG2_N(0)) dut0 (
        .clk(clk), .reset(reset), .bitout(bitout), .conv_done(conv_done),
        .flush(flush), .ovr_clr(ovr_clr), .avg_ready(avg_ready),
        .avg_out(out0), .avg_valid(valid0), .overrun(ovr0), .sample_cnt(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step(input int k, input int n);
        bit cap;
        bit xfer;
        bit have_res;
        bit ovr_ev;
        int sum;
        int res;
        if (reset) begin
            m_out[k] = 0; m_valid[k] = 0; m_ovr[k] = 0; m_prev[k] = 0; m_n[k] = 0;
            return;
        end
        cap      = conv_done && !m_prev[k];
        xfer     = m_valid[k] && avg_ready;
        have_res = 0;
        ovr_ev   = 0;
        res      = 0;
        if (flush) begin
            m_n[k] = 0;
        end else if (cap) begin
            m_blk[k][m_n[k]] = int'(bitout);
            m_n[k] = m_n[k] + 1;
            if (m_n[k] == n) begin
                sum = 0;
                for (int i = 0; i < n; i++) sum += m_blk[k][i];
                res = sum / n;
                m_n[k] = 0;
                have_res = 1;
            end
        end
        if (have_res) begin
            if (!m_valid[k] || xfer) begin
                m_out[k] = res;
                m_valid[k] = 1;
            end else begin
                ovr_ev = 1;
            end
        end else if (xfer) begin
            m_valid[k] = 0;
        end
        if (ovr_ev) m_ovr[k] = 1;
        else if (ovr_clr) m_ovr[k] = 0;
        m_prev[k] = conv_done;
    endtask

    task automatic cycle();
        model_step(0, 4);
        model_step(1, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int v);
        bitout = 12'(v);
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        checks++; if (out2 !== 12'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", out2); end
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid2); end
        checks++; if (ovr2 !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b exp 0", ovr2); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt2); end
    endtask

    task automatic test_basic();
        avg_ready = 1'b1;
        cap(100); cap(200);
        cap(300);
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL basic_cnt got %0d exp 3", cnt2); end
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", valid2); end
        bitout = 12'd400; conv_done = 1'b1;
        cycle();
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", valid2); end
        checks++; if (out2 !== 12'd250) begin errors++; $display("FAIL basic_out got %0d exp 250", out2); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL basic_cnt_wrap got %0d exp 0", cnt2); end
        conv_done = 1'b0;
        cycle();
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0b exp 0", valid2); end
    endtask

    task automatic test_max_trunc();
        avg_ready = 1'b1;
        cap(4095); cap(4095); cap(4095);
        bitout = 12'd4095; conv_done = 1'b1;
        cycle();
        checks++; if (out2 !== 12'd4095) begin errors++; $display("FAIL max_out got %0d exp 4095", out2); end
        conv_done = 1'b0;
        cycle();
        cap(1); cap(1); cap(1);
        bitout = 12'd2; conv_done = 1'b1;
        cycle();
        checks++; if (out2 !== 12'd1) begin errors++; $display("FAIL trunc_out got %0d exp 1", out2); end
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL trunc_valid got %0b exp 1", valid2); end
        conv_done = 1'b0;
        cycle();
    endtask

    task automatic test_overrun();
        avg_ready = 1'b0;
        cap(10); cap(20); cap(30); cap(40);
        cap(1000); cap(1000); cap(1000); cap(1000);
        checks++; if (out2 !== 12'd25) begin errors++; $display("FAIL ovr_hold_out got %0d exp 25", out2); end
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got %0b exp 1", valid2); end
        checks++; if (ovr2 !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", ovr2); end
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        checks++; if (ovr2 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", ovr2); end
        cap(7); cap(7); cap(7);
        bitout = 12'd7; conv_done = 1'b1; ovr_clr = 1'b1;
        cycle();
        checks++; if (ovr2 !== 1'b1) begin errors++; $display("FAIL ovr_wins_clr got %0b exp 1", ovr2); end
        checks++; if (out2 !== 12'd25) begin errors++; $display("FAIL ovr_keep_out got %0d exp 25", out2); end
        conv_done = 1'b0; avg_ready = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL ovr_drain got %0b exp 0", valid2); end
        checks++; if (ovr2 !== 1'b0) begin errors++; $display("FAIL ovr_reclear got %0b exp 0", ovr2); end
    endtask

    task automatic test_flush();
        avg_ready = 1'b1;
        cap(500); cap(500);
        checks++; if (cnt2 !== 2'd2) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 2", cnt2); end
        flush = 1'b1; bitout = 12'd999; conv_done = 1'b1;
        cycle();
        flush = 1'b0; conv_done = 1'b0;
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", cnt2); end
        cycle();
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL flush_discard got %0d exp 0", cnt2); end
        cap(8); cap(8); cap(8);
        bitout = 12'd8; conv_done = 1'b1;
        cycle();
        checks++; if (out2 !== 12'd8) begin errors++; $display("FAIL flush_out got %0d exp 8", out2); end
        conv_done = 1'b0;
        cycle();
    endtask

    task automatic test_hold_and_reset();
        avg_ready = 1'b1;
        bitout = 12'd5; conv_done = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (cnt2 !== 2'd1) begin errors++; $display("FAIL hold_cnt got %0d exp 1", cnt2); end
        conv_done = 1'b0;
        cycle();
        cap(5); cap(5);
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL hold_cnt3 got %0d exp 3", cnt2); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++; if (out2 !== 12'd0) begin errors++; $display("FAIL midrst_out got %0d exp 0", out2); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", cnt2); end
        checks++; if (valid2 !== 1'b0 || ovr2 !== 1'b0) begin errors++; $display("FAIL midrst_flags got %0b%0b exp 00", valid2, ovr2); end
        cap(40); cap(40); cap(40);
        bitout = 12'd44; conv_done = 1'b1;
        cycle();
        checks++; if (out2 !== 12'd41) begin errors++; $display("FAIL midrst_avg got %0d exp 41", out2); end
        conv_done = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        avg_ready = 1'b0;
        cap(10); cap(20); cap(30); cap(40);
        checks++; if (out2 !== 12'd25 || valid2 !== 1'b1) begin errors++; $display("FAIL b2b_first got %0d/%0b exp 25/1", out2, valid2); end
        cap(100); cap(100); cap(100);
        bitout = 12'd104; conv_done = 1'b1; avg_ready = 1'b1;
        cycle();
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", valid2); end
        checks++; if (out2 !== 12'd101) begin errors++; $display("FAIL b2b_out got %0d exp 101", out2); end
        checks++; if (ovr2 !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %0b exp 0", ovr2); end
        conv_done = 1'b0;
        cycle();
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", valid2); end
    endtask

    task automatic test_log2n0();
        int v;
        avg_ready = 1'b1; ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 4095));
            bitout = 12'(v); conv_done = 1'b1;
            cycle();
            checks++; if (out0 !== 12'(v) || valid0 !== 1'b1) begin errors++; $display("FAIL n0_track got %0d/%0b exp %0d/1", out0, valid0, v); end
            checks++; if (ovr0 !== 1'b0 || cnt0 !== 1'b0) begin errors++; $display("FAIL n0_flags got %0b/%0d exp 0/0", ovr0, cnt0); end
            conv_done = 1'b0;
            cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 127) == 0);
            conv_done = 1'($urandom_range(0, 1));
            bitout    = 12'($urandom_range(0, 4095));
            avg_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            ovr_clr   = ($urandom_range(0, 7) == 0);
            cycle();
            checks++; if (out2 !== 12'(m_out[0])) begin errors++; $display("FAIL rnd_out c%0d got %0d exp %0d", c, out2, m_out[0]); end
            checks++; if (valid2 !== m_valid[0]) begin errors++; $display("FAIL rnd_valid c%0d got %0b exp %0b", c, valid2, m_valid[0]); end
            checks++; if (ovr2 !== m_ovr[0]) begin errors++; $display("FAIL rnd_ovr c%0d got %0b exp %0b", c, ovr2, m_ovr[0]); end
            checks++; if (cnt2 !== 2'(m_n[0])) begin errors++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", c, cnt2, m_n[0]); end
            checks++; if (out0 !== 12'(m_out[1])) begin errors++; $display("FAIL rnd_n0_out c%0d got %0d exp %0d", c, out0, m_out[1]); end
            checks++; if (valid0 !== m_valid[1]) begin errors++; $display("FAIL rnd_n0_valid c%0d got %0b exp %0b", c, valid0, m_valid[1]); end
            checks++; if (ovr0 !== m_ovr[1]) begin errors++; $display("FAIL rnd_n0_ovr c%0d got %0b exp %0b", c, ovr0, m_ovr[1]); end
        end
        reset = 1'b0; conv_done = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; bitout = '0; conv_done = 1'b0; flush = 1'b0;
        ovr_clr = 1'b0; avg_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_valid[k] = 0; m_ovr[k] = 0; m_prev[k] = 0; m_n[k] = 0;
        end
        test_reset();
        test_basic();
        test_max_trunc();
        test_overrun();
        test_flush();
        test_hold_and_reset();
        test_back_to_back();
        test_log2n0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sar_avg_decim
